// File: rtl/systolic_pkg.sv
// Shared widths, output saturation helper and bus lane-slice macro for the systolic MAC array.
// Pure definitions: no latency, no flow control.
`ifndef SYSTOLIC_LANE_MACROS
`define SYSTOLIC_LANE_MACROS
`define SA_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package systolic_pkg;
  localparam int IDW = 8;
  localparam int WDW = 8;
  localparam int ODW = 32;

  localparam logic signed [ODW-1:0] SAT_MAX = ODW'((1 << (IDW - 1)) - 1);
  localparam logic signed [ODW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [IDW-1:0] sat_to_idw(input logic signed [ODW-1:0] v);
    logic signed [IDW-1:0] r;
    if (v > SAT_MAX)
      r = SAT_MAX[IDW-1:0];
    else if (v < SAT_MIN)
      r = SAT_MIN[IDW-1:0];
    else
      r = v[IDW-1:0];
    return r;
  endfunction
endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary MAC cell; a_out and p_out are registered, 1 cycle after a_in/p_in.
// No backpressure: en=0 freezes every register; save copies the current a_reg into the weight.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int A_W = IDW,
  parameter int W_W = WDW,
  parameter int P_W = ODW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  save,
  input  logic signed [A_W-1:0] a_in,
  input  logic signed [P_W-1:0] p_in,
  output logic signed [A_W-1:0] a_out,
  output logic signed [P_W-1:0] p_out
);
  logic signed [A_W-1:0]     a_reg;
  logic signed [W_W-1:0]     w_reg;
  logic signed [P_W-1:0]     p_reg;
  logic signed [A_W+W_W-1:0] prod;

  assign prod  = a_in * w_reg;
  assign a_out = a_reg;
  assign p_out = p_reg;

  // The MAC reads w_reg before any save in the same cycle takes effect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_reg <= '0;
      w_reg <= '0;
      p_reg <= '0;
    end else if (en) begin
      a_reg <= a_in;
      p_reg <= p_in + {{(P_W-A_W-W_W){prod[A_W+W_W-1]}}, prod};
      if (save)
        w_reg <= a_reg;
    end
  end
endmodule

// File: rtl/systolic_array.sv
// PE_ROW x PE_COL weight-stationary int8 MAC grid; psum latency PE_ROW cycles, a-lane r reaches column c after c+1.
// No handshake: per-row enable stalls a row in place; save loads weights from the shifted a-values.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int PE_ROW            = 16,
  parameter int PE_COL            = 16,
  parameter int INPUT_DATA_WIDTH  = IDW,
  parameter int WEIGHT_DATA_WIDTH = WDW,
  parameter int OUTPUT_DATA_WIDTH = ODW
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [PE_ROW*INPUT_DATA_WIDTH-1:0] in_a_bus,
  input  logic [PE_COL*INPUT_DATA_WIDTH-1:0] in_b_bus,
  input  logic [PE_ROW-1:0]                  enable,
  input  logic                               save,
  output logic [PE_ROW*INPUT_DATA_WIDTH-1:0] out_a_bus,
  output logic [PE_COL*INPUT_DATA_WIDTH-1:0] out_b_bus
);
  localparam int AW = INPUT_DATA_WIDTH;
  localparam int PW = OUTPUT_DATA_WIDTH;

  logic signed [AW-1:0] a_w [PE_ROW][PE_COL+1];
  logic signed [PW-1:0] p_w [PE_ROW+1][PE_COL];

  for (genvar r = 0; r < PE_ROW; r++) begin : g_row_io
    assign a_w[r][0] = `SA_LANE(in_a_bus, r, AW);
    assign `SA_LANE(out_a_bus, r, AW) = a_w[r][PE_COL];
  end

  // Top psum lanes are sign-extended into the accumulator; bottom lanes clamp back to int8.
  for (genvar c = 0; c < PE_COL; c++) begin : g_col_io
    assign p_w[0][c] = {{(PW-AW){in_b_bus[c*AW+AW-1]}}, `SA_LANE(in_b_bus, c, AW)};
    assign `SA_LANE(out_b_bus, c, AW) = sat_to_idw(p_w[PE_ROW][c]);
  end

  for (genvar r = 0; r < PE_ROW; r++) begin : g_r
    for (genvar c = 0; c < PE_COL; c++) begin : g_c
      systolic_pe #(
        .A_W (AW),
        .W_W (WEIGHT_DATA_WIDTH),
        .P_W (PW)
      ) u_pe (
        .clk   (clk),
        .rstn  (rstn),
        .en    (enable[r]),
        .save  (save),
        .a_in  (a_w[r][c]),
        .p_in  (p_w[r][c]),
        .a_out (a_w[r][c+1]),
        .p_out (p_w[r+1][c])
      );
    end
  end
endmodule

// File: tb/tb_systolic_array.sv
// Directed-phase bench with random data, checked against a history-based array model.
module tb_systolic_array;
  localparam int R = 16;
  localparam int C = 16;
  localparam int W = 8;
  localparam int MAXE = 1024;

  logic clk = 1'b0;
  logic rstn;
  logic [R*W-1:0] in_a_bus;
  logic [C*W-1:0] in_b_bus;
  logic [R-1:0]   enable;
  logic           save;
  logic [R*W-1:0] out_a_bus;
  logic [C*W-1:0] out_b_bus;

  logic signed [W-1:0] a_v [R];
  logic signed [W-1:0] b_v [C];
  logic signed [W-1:0] a_h [MAXE][R];
  logic signed [W-1:0] b_h [MAXE][C];
  int ls_h [MAXE];
  int wm [R][C];
  int e = 0;
  int errors = 0;
  int checks = 0;

  systolic_array dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_a_bus  (in_a_bus),
    .in_b_bus  (in_b_bus),
    .enable    (enable),
    .save      (save),
    .out_a_bus (out_a_bus),
    .out_b_bus (out_b_bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_a_bus = '0;
    in_b_bus = '0;
    for (int r = 0; r < R; r++) in_a_bus[r*W +: W] = a_v[r];
    for (int c = 0; c < C; c++) in_b_bus[c*W +: W] = b_v[c];
  end

  // Reference: values sampled at edge t; negative edges mean "before reset release" (all zero).
  function automatic int a_at(int r, int t);
    return (t < 0) ? 0 : int'(a_h[t][r]);
  endfunction

  function automatic int b_at(int c, int t);
    return (t < 0) ? 0 : int'(b_h[t][c]);
  endfunction

  // Weight in force during edge t: set by the latest save strictly before t.
  function automatic int w_at(int r, int c, int t);
    int s;
    if (t <= 0) return 0;
    s = ls_h[t-1];
    if (s < 0) return 0;
    return a_at(r, s - 1 - c);
  endfunction

  function automatic int sat8(int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Output after edge T: psum entered at edge T-15, met row r at edge s+r.
  function automatic int exp_b(int c, int t);
    int s;
    int acc;
    s = t - (R - 1);
    acc = b_at(c, s);
    for (int r = 0; r < R; r++)
      acc += a_at(r, s + r - c) * w_at(r, c, s + r);
    return sat8(acc);
  endfunction

  function automatic logic signed [31:0] lane_b(int c);
    logic signed [W-1:0] t;
    t = out_b_bus[c*W +: W];
    return 32'(t);
  endfunction

  function automatic logic signed [31:0] lane_a(int r);
    logic signed [W-1:0] t;
    t = out_a_bus[r*W +: W];
    return 32'(t);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e - 1, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e - 1, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [C*W-1:0] eb;
    logic [R*W-1:0] ea;
    for (int c = 0; c < C; c++) eb[c*W +: W] = W'(exp_b(c, e - 1));
    for (int r = 0; r < R; r++) ea[r*W +: W] = W'(a_at(r, e - 1 - (C - 1)));
    chk_bus("out_b_model", out_b_bus, eb);
    chk_bus("out_a_model", out_a_bus, ea);
  endtask

  task automatic tick(input bit do_check);
    @(posedge clk);
    if (e >= MAXE) begin
      $display("FAIL history_overflow edge=%0d limit=%0d", e, MAXE);
      $fatal(1);
    end
    for (int r = 0; r < R; r++) a_h[e][r] = a_v[r];
    for (int c = 0; c < C; c++) b_h[e][c] = b_v[c];
    ls_h[e] = save ? e : ((e == 0) ? -1 : ls_h[e-1]);
    e++;
    #1;
    if (do_check) check_all();
  endtask

  task automatic rand_a();
    for (int r = 0; r < R; r++) a_v[r] = W'($urandom_range(255));
  endtask

  task automatic rand_b();
    for (int c = 0; c < C; c++) b_v[c] = W'($urandom_range(255));
  endtask

  // Column c weight goes in 15-c cycles after t0; save lands at t0+16.
  task automatic load_w();
    for (int k = 0; k < C; k++) begin
      for (int r = 0; r < R; r++) a_v[r] = W'(wm[r][C-1-k]);
      for (int c = 0; c < C; c++) b_v[c] = '0;
      tick(1'b1);
    end
    save = 1'b1;
    rand_a();
    tick(1'b1);
    save = 1'b0;
  endtask

  initial begin
    int base;
    int stall0;
    int fz;
    int ac [R];
    int bc [C];
    int acc;

    // Reset with busy inputs and save asserted
    rstn = 1'b0;
    save = 1'b1;
    enable = '1;
    rand_a();
    for (int r = 0; r < R; r++) if (a_v[r] == 0) a_v[r] = 8'sd5;
    rand_b();
    for (int c = 0; c < C; c++) if (b_v[c] == 0) b_v[c] = -8'sd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_bus("reset_out_a", {{(128-R*W){1'b0}}, out_a_bus}, '0);
      chk_bus("reset_out_b", {{(128-C*W){1'b0}}, out_b_bus}, '0);
    end
    rstn = 1'b1;
    save = 1'b0;
    #1;
    chk_bus("post_reset_out_a", {{(128-R*W){1'b0}}, out_a_bus}, '0);
    chk_bus("post_reset_out_b", {{(128-C*W){1'b0}}, out_b_bus}, '0);

    // Identity weights, skewed vector 1..16
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = (r == c) ? 1 : 0;
    load_w();
    base = e;
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < R; r++) a_v[r] = (k == r) ? W'(r + 1) : '0;
      for (int c = 0; c < C; c++) b_v[c] = '0;
      tick(1'b1);
      for (int c = 0; c < C; c++)
        if (e - 1 == base + (R - 1) + c) chk("identity_lane", lane_b(c), 32'(c + 1));
    end

    // Zero weights: psum passes straight through after PE_ROW cycles
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = 0;
    load_w();
    base = e;
    for (int k = 0; k < 24; k++) begin
      rand_a();
      for (int c = 0; c < C; c++) b_v[c] = (k == 0) ? W'(c - 8) : '0;
      tick(1'b1);
      if (e - 1 == base + (R - 1))
        for (int c = 0; c < C; c++) chk("psum_pass_lane", lane_b(c), 32'(c - 8));
    end

    // Random weights, random activations and psums
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = int'($urandom_range(255)) - 128;
    load_w();
    for (int k = 0; k < 40; k++) begin
      rand_a();
      rand_b();
      tick(1'b1);
    end

    // Saturation high then low
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = 127;
    load_w();
    for (int k = 0; k < 32; k++) begin
      for (int r = 0; r < R; r++) a_v[r] = 8'sd127;
      for (int c = 0; c < C; c++) b_v[c] = '0;
      tick(1'b1);
    end
    for (int c = 0; c < C; c++) chk("sat_high_lane", lane_b(c), 32'sd127);
    for (int k = 0; k < 32; k++) begin
      for (int r = 0; r < R; r++) a_v[r] = -8'sd128;
      tick(1'b1);
    end
    for (int c = 0; c < C; c++) chk("sat_low_lane", lane_b(c), -32'sd128);

    // Save while streaming: the streamed values become the new weights
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = int'($urandom_range(15)) - 7;
    load_w();
    for (int k = 0; k < 50; k++) begin
      for (int r = 0; r < R; r++) a_v[r] = W'(int'($urandom_range(15)) - 7);
      rand_b();
      save = (k == 20);
      tick(1'b1);
    end
    save = 1'b0;

    // Row 5 stall with a save pulse that row 5 must ignore
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = int'($urandom_range(6)) - 3;
    load_w();
    for (int r = 0; r < R; r++) ac[r] = int'($urandom_range(4)) - 2;
    if (ac[5] == 0) ac[5] = 2;
    for (int c = 0; c < C; c++) bc[c] = int'($urandom_range(40)) - 20;
    for (int k = 0; k < 20; k++) begin
      for (int r = 0; r < R; r++) a_v[r] = (r == 5) ? W'($urandom_range(255)) : W'(ac[r]);
      for (int c = 0; c < C; c++) b_v[c] = W'(bc[c]);
      tick(1'b1);
    end
    stall0 = e;
    fz = a_at(5, stall0 - 1 - (C - 1));
    enable[5] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_v[5] = W'($urandom_range(255));
      save = (k == 1);
      tick(1'b0);
      chk("stall_row5_out_a", lane_a(5), 32'(fz));
      chk("stall_row0_out_a", lane_a(0), 32'(ac[0]));
    end
    save = 1'b0;
    enable = '1;
    a_v[5] = W'(ac[5]);
    for (int k = 0; k < 40; k++) tick(1'b0);
    for (int c = 0; c < C; c++) begin
      acc = bc[c];
      for (int r = 0; r < R; r++) acc += ac[r] * ((r == 5) ? wm[r][c] : ac[r]);
      chk("stall_resume_lane", lane_b(c), 32'(sat8(acc)));
    end
    chk("stall_resume_out_a5", lane_a(5), 32'(ac[5]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
